// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: one-clock enable strobes every D clocks, for a burst of L pulses or until stopped
module enable_pulse_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic [CNT_W-1:0] i_burst_len,
    output logic             o_en,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;
    logic [DIV_W-1:0] pc, pc_d, div, div_d;
    logic [CNT_W-1:0] nc, nc_d, len, len_d;
    logic en_d, done_d, wrap, last;
    always_comb begin
        wrap    = pc == DIV_W'(div - 1'b1);
        last    = len != '0 && CNT_W'(nc + 1'b1) == len;
        state_d = state;
        pc_d    = pc;
        nc_d    = nc;
        div_d   = div;
        len_d   = len;
        en_d    = 1'b0;
        done_d  = 1'b0;
        if (state == IDLE) begin
            if (i_start && !i_stop) begin
                state_d = RUN;
                pc_d    = '0;
                nc_d    = '0;
                div_d   = i_divisor == '0 ? DIV_W'(1) : i_divisor;
                len_d   = i_burst_len;
            end
        end else if (i_stop) begin
            state_d = IDLE;
        end else if (wrap) begin
            pc_d    = '0;
            en_d    = 1'b1;
            nc_d    = nc == '1 ? nc : CNT_W'(nc + 1'b1);
            done_d  = last;
            state_d = last ? IDLE : RUN;
        end else begin
            pc_d = DIV_W'(pc + 1'b1);
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            pc     <= '0;
            nc     <= '0;
            div    <= '0;
            len    <= '0;
            o_en   <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            nc     <= nc_d;
            div    <= div_d;
            len    <= len_d;
            o_en   <= en_d;
            o_busy <= state_d == RUN;
            o_done <= done_d;
        end
    end
endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb_enable_pulse_gen: directed checks of enable_pulse_gen timing, bursts, stop, reset and restart
module tb_enable_pulse_gen;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [15:0] i_divisor = '0;
    logic [7:0]  i_burst_len = '0;
    logic        o_en, o_busy, o_done;
    int tests = 0;
    int fails = 0;

    enable_pulse_gen #(.DIV_W(16), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_divisor(i_divisor), .i_burst_len(i_burst_len),
        .o_en(o_en), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] d, input logic [7:0] l);
        i_divisor = d;
        i_burst_len = l;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_start = k[0];
            i_stop = k[1];
            i_divisor = 16'(k + 1);
            i_burst_len = 8'(k);
            tick();
            tests++;
            if ({o_en, o_busy, o_done} !== 3'b000) begin
                fails++;
                $display("FAIL reset_hold k=%0d got en/busy/done=%b exp 000", k, {o_en, o_busy, o_done});
            end
        end
        i_start = 1'b0;
        i_stop = 1'b0;
        #3 i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({o_en, o_busy, o_done} !== 3'b000) begin
                fails++;
                $display("FAIL reset_release k=%0d got en/busy/done=%b exp 000", k, {o_en, o_busy, o_done});
            end
        end
    endtask

    task automatic test_burst();
        launch(16'd4, 8'd3);
        for (int k = 1; k <= 14; k++) begin
            tick();
            tests++;
            if (o_en !== (k % 4 == 0 && k <= 12)) begin
                fails++;
                $display("FAIL burst_en edge=%0d got %b exp %b", k, o_en, (k % 4 == 0 && k <= 12));
            end
            tests++;
            if (o_done !== (k == 12)) begin
                fails++;
                $display("FAIL burst_done edge=%0d got %b exp %b", k, o_done, (k == 12));
            end
            tests++;
            if (o_busy !== (k < 12)) begin
                fails++;
                $display("FAIL burst_busy edge=%0d got %b exp %b", k, o_busy, (k < 12));
            end
        end
    endtask

    task automatic test_small_div();
        for (int d = 0; d < 2; d++) begin
            launch(16'(d), 8'd5);
            for (int k = 1; k <= 7; k++) begin
                tick();
                tests++;
                if ({o_en, o_done, o_busy} !== {k <= 5, k == 5, k < 5}) begin
                    fails++;
                    $display("FAIL small_div d=%0d edge=%0d got en/done/busy=%b exp %b", d, k,
                             {o_en, o_done, o_busy}, {k <= 5, k == 5, k < 5});
                end
            end
        end
    endtask

    task automatic test_continuous();
        launch(16'd3, 8'd0);
        for (int k = 1; k <= 10; k++) begin
            i_stop = (k == 7);
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== {k == 3 || k == 6, 1'b0, k < 7}) begin
                fails++;
                $display("FAIL cont_stop edge=%0d got en/done/busy=%b exp %b", k,
                         {o_en, o_done, o_busy}, {k == 3 || k == 6, 1'b0, k < 7});
            end
        end
        launch(16'd3, 8'd0);
        for (int k = 1; k <= 11; k++) begin
            i_stop = (k == 9);
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== {k == 3 || k == 6, 1'b0, k < 9}) begin
                fails++;
                $display("FAIL cont_stop_on_pulse edge=%0d got en/done/busy=%b exp %b", k,
                         {o_en, o_done, o_busy}, {k == 3 || k == 6, 1'b0, k < 9});
            end
        end
        i_stop = 1'b0;
    endtask

    task automatic test_ignore();
        launch(16'd5, 8'd2);
        for (int k = 1; k <= 12; k++) begin
            i_start = (k == 2);
            if (k == 2) begin
                i_divisor = 16'd2;
                i_burst_len = 8'd1;
            end
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== {k == 5 || k == 10, k == 10, k < 10}) begin
                fails++;
                $display("FAIL ignore_run edge=%0d got en/done/busy=%b exp %b", k,
                         {o_en, o_done, o_busy}, {k == 5 || k == 10, k == 10, k < 10});
            end
        end
        i_start = 1'b1;
        i_stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== 3'b000) begin
                fails++;
                $display("FAIL start_stop_idle k=%0d got en/done/busy=%b exp 000", k, {o_en, o_done, o_busy});
            end
        end
        i_start = 1'b0;
        i_stop = 1'b0;
    endtask

    task automatic test_back_to_back();
        launch(16'd4, 8'd3);
        for (int k = 1; k <= 5; k++) tick();
        #3 i_rst_n = 1'b0;
        #1;
        tests++;
        if ({o_en, o_done, o_busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_async got en/done/busy=%b exp 000", {o_en, o_done, o_busy});
        end
        for (int k = 0; k < 8; k++) begin
            if (k == 2) i_rst_n = 1'b1;
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== 3'b000) begin
                fails++;
                $display("FAIL reset_mid_after k=%0d got en/done/busy=%b exp 000", k, {o_en, o_done, o_busy});
            end
        end
        launch(16'd2, 8'd2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== {k == 2 || k == 4, k == 4, k < 4}) begin
                fails++;
                $display("FAIL b2b_first edge=%0d got en/done/busy=%b exp %b", k,
                         {o_en, o_done, o_busy}, {k == 2 || k == 4, k == 4, k < 4});
            end
        end
        launch(16'd3, 8'd1);
        tests++;
        if (o_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept got busy=%b exp 1", o_busy);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if ({o_en, o_done, o_busy} !== {k == 3, k == 3, k < 3}) begin
                fails++;
                $display("FAIL b2b_second edge=%0d got en/done/busy=%b exp %b", k,
                         {o_en, o_done, o_busy}, {k == 3, k == 3, k < 3});
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_small_div();
        test_continuous();
        test_ignore();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
